// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops entries with one-cycle read latency and packs
// PACK_COUNT of them (lane 0 first) into a wide word on a valid/ready handshake.
module fifo_rd_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int PACK_COUNT = 4,
  parameter int CNT_WIDTH  = 3
) (
  input  logic                             rd_clk_pk,
  input  logic                             rst_in_rd_pk,
  input  logic                             empty_st_pk,
  input  logic [DATA_WIDTH-1:0]            data_in_pk,
  output logic                             rd_en_pk,
  input  logic                             pop_err_in_pk,
  input  logic                             flush_pk,
  output logic [DATA_WIDTH*PACK_COUNT-1:0] word_out_pk,
  output logic [CNT_WIDTH-1:0]             word_cnt_pk,
  output logic                             word_valid_pk,
  input  logic                             word_ready_pk,
  output logic                             err_sticky_pk
);

  localparam int WORD_WIDTH = DATA_WIDTH * PACK_COUNT;
  localparam logic [CNT_WIDTH-1:0] FULL     = CNT_WIDTH'(PACK_COUNT);
  localparam logic [CNT_WIDTH:0]   FULL_EXT = (CNT_WIDTH + 1)'(PACK_COUNT);

  typedef enum logic {
    FILL,
    HOLD
  } state_t;

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   count, count_next, capture_count;
  logic                   inflight, inflight_next;
  logic                   flush_pending, flush_pending_next;
  logic [WORD_WIDTH-1:0]  word_next;
  logic [CNT_WIDTH-1:0]   cnt_next;
  logic                   valid_next;
  logic                   err_next;

  // Counting the in-flight pop keeps back-to-back reads from overfilling the word.
  assign rd_en_pk = (state == FILL) && !empty_st_pk && !flush_pending &&
                    (({1'b0, count} + {{CNT_WIDTH{1'b0}}, inflight}) < FULL_EXT) &&
                    !rst_in_rd_pk;

  always_comb begin
    state_next         = state;
    count_next         = count;
    capture_count      = count;
    inflight_next      = rd_en_pk && !empty_st_pk;
    flush_pending_next = flush_pending;
    word_next          = word_out_pk;
    cnt_next           = word_cnt_pk;
    valid_next         = word_valid_pk;
    err_next           = err_sticky_pk || pop_err_in_pk;

    case (state)
      FILL: begin
        if (inflight) begin
          for (int i = 0; i < PACK_COUNT; i++) begin
            if (count == CNT_WIDTH'(i)) begin
              word_next[i*DATA_WIDTH +: DATA_WIDTH] = data_in_pk;
            end
          end
          capture_count = count + CNT_WIDTH'(1);
        end
        count_next = capture_count;

        // A completing capture beats any flush since nothing partial is left.
        if (inflight && (capture_count == FULL)) begin
          state_next         = HOLD;
          cnt_next           = FULL;
          valid_next         = 1'b1;
          flush_pending_next = 1'b0;
        end else if (flush_pending && !inflight) begin
          flush_pending_next = 1'b0;
          if (count != '0) begin
            state_next = HOLD;
            cnt_next   = count;
            valid_next = 1'b1;
          end
        end else if (flush_pk) begin
          flush_pending_next = 1'b1;
        end
      end

      HOLD: begin
        if (word_ready_pk) begin
          state_next         = FILL;
          valid_next         = 1'b0;
          word_next          = '0;
          cnt_next           = '0;
          count_next         = '0;
          flush_pending_next = 1'b0;
        end
      end

      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge rd_clk_pk) begin
    if (rst_in_rd_pk) begin
      state         <= FILL;
      count         <= '0;
      inflight      <= 1'b0;
      flush_pending <= 1'b0;
      word_out_pk   <= '0;
      word_cnt_pk   <= '0;
      word_valid_pk <= 1'b0;
      err_sticky_pk <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      inflight      <= inflight_next;
      flush_pending <= flush_pending_next;
      word_out_pk   <= word_next;
      word_cnt_pk   <= cnt_next;
      word_valid_pk <= valid_next;
      err_sticky_pk <= err_next;
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO model feeds the DUT and a
// scoreboard groups pushed entries into expected words.
module tb_fifo_rd_packer;

  localparam int DW = 4;
  localparam int PC = 4;
  localparam int CW = 3;
  localparam int WW = DW * PC;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          empty_st_pk = 1'b1;
  logic [DW-1:0] data_in_pk = '0;
  logic          rd_en_pk;
  logic          pop_err_in_pk = 1'b0;
  logic          flush_pk = 1'b0;
  logic [WW-1:0] word_out_pk;
  logic [CW-1:0] word_cnt_pk;
  logic          word_valid_pk;
  logic          word_ready_pk = 1'b0;
  logic          err_sticky_pk;

  always #5 clk = ~clk;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_COUNT(PC), .CNT_WIDTH(CW)) dut (
    .rd_clk_pk     (clk),
    .rst_in_rd_pk  (rst),
    .empty_st_pk   (empty_st_pk),
    .data_in_pk    (data_in_pk),
    .rd_en_pk      (rd_en_pk),
    .pop_err_in_pk (pop_err_in_pk),
    .flush_pk      (flush_pk),
    .word_out_pk   (word_out_pk),
    .word_cnt_pk   (word_cnt_pk),
    .word_valid_pk (word_valid_pk),
    .word_ready_pk (word_ready_pk),
    .err_sticky_pk (err_sticky_pk)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] acc_q[$];
  logic [WW-1:0] exp_word_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  logic [WW-1:0] got_word_q[$];
  logic [CW-1:0] got_cnt_q[$];

  logic stall = 1'b0;
  int   cyc = 0;
  int   valid_cycles, pop_total, first_pop_cyc, last_pop_cyc, first_valid_cyc, rd_en_on_empty;

  // One clock: sample at the falling edge, apply FIFO read data after the rising edge.
  task automatic tick();
    bit pop;
    empty_st_pk = (fifo_q.size() == 0) || stall;
    @(negedge clk);
    cyc++;
    if (rd_en_pk && empty_st_pk) rd_en_on_empty++;
    pop = rd_en_pk && !empty_st_pk;
    if (pop) begin
      pop_total++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    if (word_valid_pk) begin
      valid_cycles++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (word_valid_pk && word_ready_pk && !rst) begin
      got_word_q.push_back(word_out_pk);
      got_cnt_q.push_back(word_cnt_pk);
    end
    @(posedge clk);
    #1;
    if (pop) data_in_pk = fifo_q.pop_front();
  endtask

  task automatic reset_stats();
    valid_cycles    = 0;
    pop_total       = 0;
    first_pop_cyc   = -1;
    last_pop_cyc    = -1;
    first_valid_cyc = -1;
    rd_en_on_empty  = 0;
  endtask

  task automatic clear_scoreboard();
    acc_q.delete();
    exp_word_q.delete();
    exp_cnt_q.delete();
    got_word_q.delete();
    got_cnt_q.delete();
  endtask

  task automatic emit_expected();
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < acc_q.size(); i++) w[i*DW +: DW] = acc_q[i];
    exp_word_q.push_back(w);
    exp_cnt_q.push_back(CW'(acc_q.size()));
    acc_q.delete();
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    acc_q.push_back(v);
    if (acc_q.size() == PC) emit_expected();
  endtask

  task automatic model_flush();
    if (acc_q.size() > 0) emit_expected();
  endtask

  task automatic run_until_words(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (got_word_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    fifo_q.push_back(4'h5);
    tick();
    vectors++;
    if (rd_en_pk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_rd_en: got %b expected 0", rd_en_pk);
    end
    vectors++;
    if (word_out_pk !== '0 || word_cnt_pk !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_word: got %h/%0d expected 0/0", word_out_pk, word_cnt_pk);
    end
    vectors++;
    if (word_valid_pk !== 1'b0 || err_sticky_pk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_flags: got valid=%b err=%b expected 0/0", word_valid_pk, err_sticky_pk);
    end
    rst = 1'b0;
    fifo_q.delete();
  endtask

  task automatic test_basic();
    bit ok;
    reset_stats();
    clear_scoreboard();
    word_ready_pk = 1'b1;
    for (int v = 1; v <= 4; v++) push(DW'(v));
    run_until_words(1, 30, ok);
    for (int i = 0; i < 4; i++) tick();
    vectors++;
    if (!ok || got_word_q.size() != 1 || got_word_q[0] !== 16'h4321 || got_cnt_q[0] !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL basic_word: got %0d words first=%h cnt=%0d expected 1 word 4321 cnt 4",
               got_word_q.size(), got_word_q.size() ? got_word_q[0] : '0, got_cnt_q.size() ? got_cnt_q[0] : '0);
    end
    vectors++;
    if (pop_total != 4 || last_pop_cyc - first_pop_cyc != 3) begin
      miscompares++;
      $display("[TB] FAIL basic_pops: got %0d pops over %0d cycles expected 4 over 3", pop_total, last_pop_cyc - first_pop_cyc);
    end
    vectors++;
    if (valid_cycles != 1 || first_valid_cyc - first_pop_cyc != 5) begin
      miscompares++;
      $display("[TB] FAIL basic_valid: got %0d valid cycles at offset %0d expected 1 at 5",
               valid_cycles, first_valid_cyc - first_pop_cyc);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int hold_bad;
    reset_stats();
    clear_scoreboard();
    word_ready_pk = 1'b0;
    hold_bad = 0;
    for (int v = 0; v < 8; v++) push(DW'(v));
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      ok = (first_valid_cyc >= 0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (word_out_pk !== 16'h3210 || word_valid_pk !== 1'b1 || rd_en_pk !== 1'b0) hold_bad++;
    end
    vectors++;
    if (!ok || hold_bad != 0) begin
      miscompares++;
      $display("[TB] FAIL hold_stable: got %0d unstable cycles (valid seen=%b) expected 0", hold_bad, ok);
    end
    word_ready_pk = 1'b1;
    run_until_words(2, 40, ok);
    vectors++;
    if (!ok || got_word_q[0] !== 16'h3210 || got_word_q[1] !== 16'h7654) begin
      miscompares++;
      $display("[TB] FAIL backpressure_words: got %0d words expected 3210 then 7654", got_word_q.size());
    end
    for (int i = 0; i < exp_word_q.size(); i++) begin
      vectors++;
      if (i >= got_word_q.size() || got_word_q[i] !== exp_word_q[i] || got_cnt_q[i] !== exp_cnt_q[i]) begin
        miscompares++;
        $display("[TB] FAIL backpressure_model[%0d]: got %h expected %h", i,
                 i < got_word_q.size() ? got_word_q[i] : '0, exp_word_q[i]);
      end
    end
  endtask

  task automatic test_flush();
    reset_stats();
    clear_scoreboard();
    word_ready_pk = 1'b1;
    push(4'hA);
    push(4'hB);
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (valid_cycles != 0) begin
      miscompares++;
      $display("[TB] FAIL flush_premature: got %0d valid cycles expected 0", valid_cycles);
    end
    flush_pk = 1'b1;
    model_flush();
    tick();
    flush_pk = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (got_word_q.size() != 1 || got_word_q[0] !== 16'h00BA || got_cnt_q[0] !== 3'd2 ||
        got_word_q[0] !== exp_word_q[0] || valid_cycles != 1) begin
      miscompares++;
      $display("[TB] FAIL flush_partial: got %0d words first=%h cnt=%0d expected 1 word 00ba cnt 2",
               got_word_q.size(), got_word_q.size() ? got_word_q[0] : '0, got_cnt_q.size() ? got_cnt_q[0] : '0);
    end

    reset_stats();
    clear_scoreboard();
    flush_pk = 1'b1;
    model_flush();
    tick();
    flush_pk = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (valid_cycles != 0) begin
      miscompares++;
      $display("[TB] FAIL flush_empty: got %0d valid cycles expected 0", valid_cycles);
    end

    // flush landing on the final-lane capture edge
    reset_stats();
    clear_scoreboard();
    for (int v = 0; v < 4; v++) push(DW'($urandom_range(0, 15)));
    for (int i = 0; i < 20 && first_pop_cyc < 0; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    flush_pk = 1'b1;
    model_flush();
    tick();
    flush_pk = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (got_word_q.size() != 1 || exp_word_q.size() != 1 || got_word_q[0] !== exp_word_q[0] ||
        got_cnt_q[0] !== 3'd4 || valid_cycles != 1) begin
      miscompares++;
      $display("[TB] FAIL flush_vs_full: got %0d words (%0d valid cycles) expected 1 full word %h",
               got_word_q.size(), valid_cycles, exp_word_q.size() ? exp_word_q[0] : '0);
    end
  endtask

  task automatic test_random_stall();
    bit ok;
    reset_stats();
    clear_scoreboard();
    for (int v = 0; v < 16; v++) push(DW'($urandom_range(0, 15)));
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      stall = (i < 40) ? ~stall : ($urandom_range(0, 2) == 0);
      word_ready_pk = ($urandom_range(0, 3) != 0);
      tick();
      ok = (got_word_q.size() >= 4);
    end
    stall = 1'b0;
    word_ready_pk = 1'b1;
    vectors++;
    if (!ok || rd_en_on_empty != 0) begin
      miscompares++;
      $display("[TB] FAIL stall_pops: got %0d words, %0d pops on empty expected 4 words, 0 pops",
               got_word_q.size(), rd_en_on_empty);
    end
    for (int i = 0; i < exp_word_q.size(); i++) begin
      vectors++;
      if (i >= got_word_q.size() || got_word_q[i] !== exp_word_q[i] || got_cnt_q[i] !== exp_cnt_q[i]) begin
        miscompares++;
        $display("[TB] FAIL stall_model[%0d]: got %h expected %h", i,
                 i < got_word_q.size() ? got_word_q[i] : '0, exp_word_q[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    reset_stats();
    clear_scoreboard();
    word_ready_pk = 1'b1;
    for (int v = 0; v < 6; v++) push(DW'($urandom_range(0, 15)));
    for (int i = 0; i < 20 && first_pop_cyc < 0; i++) tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    if (rd_en_pk !== 1'b0 || word_out_pk !== '0 || word_cnt_pk !== '0 || word_valid_pk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got rd_en=%b word=%h cnt=%0d valid=%b expected all 0",
               rd_en_pk, word_out_pk, word_cnt_pk, word_valid_pk);
    end
    vectors++;
    if (pop_total != 3 || valid_cycles != 0) begin
      miscompares++;
      $display("[TB] FAIL midreset_pops: got %0d pops %0d valid expected 3 pops 0 valid", pop_total, valid_cycles);
    end
    rst = 1'b0;
    fifo_q.delete();
    reset_stats();
    clear_scoreboard();
    for (int v = 0; v < 4; v++) push(DW'($urandom_range(0, 15)));
    run_until_words(1, 30, ok);
    vectors++;
    if (!ok || got_word_q[0] !== exp_word_q[0] || got_cnt_q[0] !== 3'd4) begin
      miscompares++;
      $display("[TB] FAIL midreset_clean: got %h expected %h", ok ? got_word_q[0] : '0, exp_word_q[0]);
    end
  endtask

  task automatic test_error();
    bit ok;
    int err_drop;
    reset_stats();
    clear_scoreboard();
    err_drop = 0;
    vectors++;
    if (err_sticky_pk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_initial: got %b expected 0", err_sticky_pk);
    end
    for (int v = 0; v < 4; v++) push(DW'($urandom_range(0, 15)));
    tick();
    pop_err_in_pk = 1'b1;
    tick();
    pop_err_in_pk = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (err_sticky_pk !== 1'b1) err_drop++;
    end
    run_until_words(1, 10, ok);
    vectors++;
    if (err_drop != 0) begin
      miscompares++;
      $display("[TB] FAIL err_sticky: got %0d cycles without error expected 0", err_drop);
    end
    vectors++;
    if (!ok || got_word_q[0] !== exp_word_q[0]) begin
      miscompares++;
      $display("[TB] FAIL err_dataflow: got %h expected %h", ok ? got_word_q[0] : '0, exp_word_q[0]);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (err_sticky_pk !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_cleared: got %b expected 0", err_sticky_pk);
    end
  endtask

  initial begin
    reset_stats();
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_random_stall();
    test_mid_reset();
    test_error();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
